// File: rtl/uart_frame_scheduler_if.sv
// -----------------------------------------------------------------------------
// uart_frame_scheduler_if
// Groups the command/sample/transmit signals that run between the frame
// scheduler and its neighbours (uart_rx, the SIPO sample path and uart_tx).
//
//   rx_ready    1                  strobe: rx_data holds a received command byte
//   rx_data     8                  received command byte
//   tx_ready    1                  uart_tx idle and able to accept a byte
//   ch_data     NUM_CH*SAMPLE_W    latest samples, channel n at [n*SAMPLE_W +: SAMPLE_W]
//   tx_send     1                  one-cycle byte-load strobe to uart_tx
//   tx_data     8                  byte to transmit
//   busy        1                  a frame is in progress
//   frame_done  1                  one-cycle pulse after the checksum byte
//   err_cmd     1                  one-cycle pulse on a rejected command
//   err_timeout 1                  one-cycle pulse on a timeout abort
//
// modport slave  : the scheduler itself
// modport master : the surrounding logic (or a testbench) driving it
// -----------------------------------------------------------------------------
interface uart_frame_scheduler_if #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned SAMPLE_W = 16
);
    logic                         rx_ready;
    logic [7:0]                   rx_data;
    logic                         tx_ready;
    logic [NUM_CH*SAMPLE_W-1:0]   ch_data;
    logic                         tx_send;
    logic [7:0]                   tx_data;
    logic                         busy;
    logic                         frame_done;
    logic                         err_cmd;
    logic                         err_timeout;

    modport master (
        output rx_ready, rx_data, tx_ready, ch_data,
        input  tx_send, tx_data, busy, frame_done, err_cmd, err_timeout
    );

    modport slave (
        input  rx_ready, rx_data, tx_ready, ch_data,
        output tx_send, tx_data, busy, frame_done, err_cmd, err_timeout
    );
endinterface

// File: rtl/uart_frame_scheduler.sv
// -----------------------------------------------------------------------------
// uart_frame_scheduler
// Sequences the shared UART transmitter for the hydrophone readout path.
// A single-byte host command selects either every channel or one channel; the
// current samples are snapshotted and streamed as
//   label(CMD_CH_BASE+ch), sample[7:0], sample[15:8]  per channel,
// followed by one checksum byte (XOR of every earlier byte of the frame).
// Each byte uses a load / wait-for-low / wait-for-high handshake on tx_ready;
// any phase that stalls for TX_TIMEOUT cycles aborts the frame.
//
// Ports:
//   clk      system clock
//   reset_b  asynchronous active-low reset
//   bus      uart_frame_scheduler_if.slave (see the interface file for signals)
// -----------------------------------------------------------------------------
module uart_frame_scheduler #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned SAMPLE_W    = 16,
    parameter logic [7:0]  CMD_ALL     = 8'h41,
    parameter logic [7:0]  CMD_CH_BASE = 8'h30,
    parameter logic [19:0] TX_TIMEOUT  = 20'd100000
) (
    input  logic                         clk,
    input  logic                         reset_b,
    uart_frame_scheduler_if.slave        bus
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_LO,
        WAIT_HI,
        DONE
    } state_t;

    state_t                      state;
    logic [NUM_CH*SAMPLE_W-1:0]  snap;
    logic [CH_W-1:0]             ch_idx;
    logic [CH_W-1:0]             last_ch;
    logic [1:0]                  byte_idx;   // 0 label, 1 LSB, 2 MSB
    logic                        cks_phase;  // next/current byte is the checksum
    logic [7:0]                  checksum;
    logic [19:0]                 timer;

    // ------------------------------------------------------------------
    // Command decode. The 9-bit subtraction exposes a borrow so bytes
    // below CMD_CH_BASE are rejected rather than wrapping into range.
    // ------------------------------------------------------------------
    logic [8:0]      cmd_off;
    logic            cmd_is_all;
    logic            cmd_is_ch;
    logic [CH_W-1:0] cmd_ch;

    assign cmd_off    = {1'b0, bus.rx_data} - {1'b0, CMD_CH_BASE};
    assign cmd_is_all = (bus.rx_data == CMD_ALL);
    assign cmd_is_ch  = !cmd_off[8] && (cmd_off[7:0] < 8'(NUM_CH));
    assign cmd_ch     = cmd_off[CH_W-1:0];

    // ------------------------------------------------------------------
    // Byte selection for the current position in the frame.
    // ------------------------------------------------------------------
    logic [SAMPLE_W-1:0] cur_sample;
    logic [15:0]         cur_word;
    logic [7:0]          next_byte;

    assign cur_sample = snap[32'(ch_idx) * SAMPLE_W +: SAMPLE_W];
    assign cur_word   = 16'(cur_sample);

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        next_byte = checksum;
        if (!cks_phase) begin
            case (byte_idx)
                2'd0:    next_byte = CMD_CH_BASE + 8'(ch_idx);
                2'd1:    next_byte = cur_word[7:0];
                default: next_byte = cur_word[15:8];
            endcase
        end
    end

    // Phase timer: saturates instead of wrapping.
    logic [19:0] timer_next;
    logic        timed_out;

    assign timer_next = (timer == '1) ? timer : timer + 20'd1;
    assign timed_out  = (timer >= TX_TIMEOUT);

    // ------------------------------------------------------------------
    // Scheduler FSM with registered outputs.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state           <= IDLE;
            snap            <= '0;
            ch_idx          <= '0;
            last_ch         <= '0;
            byte_idx        <= '0;
            cks_phase       <= 1'b0;
            checksum        <= '0;
            timer           <= '0;
            bus.tx_send     <= 1'b0;
            bus.tx_data     <= '0;
            bus.busy        <= 1'b0;
            bus.frame_done  <= 1'b0;
            bus.err_cmd     <= 1'b0;
            bus.err_timeout <= 1'b0;
        end else begin
            bus.tx_send     <= 1'b0;
            bus.frame_done  <= 1'b0;
            bus.err_cmd     <= 1'b0;
            bus.err_timeout <= 1'b0;

            // A command arriving mid-frame is dropped, even in the cycle
            // a timeout fires, so both error pulses can coincide.
            if (state != IDLE && bus.rx_ready) begin
                bus.err_cmd <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.rx_ready) begin
                        if (cmd_is_all || cmd_is_ch) begin
                            snap      <= bus.ch_data;
                            ch_idx    <= cmd_is_all ? '0 : cmd_ch;
                            last_ch   <= cmd_is_all ? CH_W'(NUM_CH - 1) : cmd_ch;
                            byte_idx  <= '0;
                            cks_phase <= 1'b0;
                            checksum  <= '0;
                            timer     <= '0;
                            bus.busy  <= 1'b1;
                            state     <= SEND;
                        end else begin
                            bus.err_cmd <= 1'b1;
                        end
                    end
                end

                SEND: begin
                    if (timed_out) begin
                        bus.err_timeout <= 1'b1;
                        bus.busy        <= 1'b0;
                        state           <= IDLE;
                    end else if (bus.tx_ready) begin
                        bus.tx_data <= next_byte;
                        bus.tx_send <= 1'b1;
                        if (!cks_phase) begin
                            checksum <= checksum ^ next_byte;
                        end
                        timer <= '0;
                        state <= WAIT_LO;
                    end else begin
                        timer <= timer_next;
                    end
                end

                WAIT_LO: begin
                    // tx_ready still reflects the idle transmitter during the
                    // strobe cycle, so it is only trusted once tx_send is low.
                    if (timed_out) begin
                        bus.err_timeout <= 1'b1;
                        bus.busy        <= 1'b0;
                        state           <= IDLE;
                    end else if (!bus.tx_send && !bus.tx_ready) begin
                        timer <= '0;
                        state <= WAIT_HI;
                    end else begin
                        timer <= timer_next;
                    end
                end

                WAIT_HI: begin
                    if (timed_out) begin
                        bus.err_timeout <= 1'b1;
                        bus.busy        <= 1'b0;
                        state           <= IDLE;
                    end else if (bus.tx_ready) begin
                        timer <= '0;
                        if (cks_phase) begin
                            state <= DONE;
                        end else begin
                            state <= SEND;
                            if (byte_idx == 2'd2) begin
                                byte_idx <= '0;
                                if (ch_idx == last_ch) begin
                                    cks_phase <= 1'b1;
                                end else begin
                                    ch_idx <= ch_idx + 1'b1;
                                end
                            end else begin
                                byte_idx <= byte_idx + 2'd1;
                            end
                        end
                    end else begin
                        timer <= timer_next;
                    end
                end

                DONE: begin
                    bus.frame_done <= 1'b1;
                    bus.busy       <= 1'b0;
                    state          <= IDLE;
                end

                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_scheduler
// Directed bench for uart_frame_scheduler (NUM_CH=4, SAMPLE_W=16,
// TX_TIMEOUT=50). A small uart_tx model drops tx_ready for 10 cycles after
// each tx_send; a monitor records every transmitted byte and counts pulse
// cycles of frame_done / err_cmd / err_timeout / busy.
// -----------------------------------------------------------------------------
module tb_uart_frame_scheduler;

    typedef logic [7:0] byte_q_t[$];

    logic clk;
    logic reset_b;

    uart_frame_scheduler_if #(.NUM_CH(4), .SAMPLE_W(16)) bus ();

    uart_frame_scheduler #(
        .NUM_CH      (4),
        .SAMPLE_W    (16),
        .CMD_ALL     (8'h41),
        .CMD_CH_BASE (8'h30),
        .TX_TIMEOUT  (20'd50)
    ) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Monitor state (written only by the monitor process).
    byte_q_t got;
    int n_done   = 0;
    int n_errcmd = 0;
    int n_errto  = 0;
    int n_busy   = 0;

    // uart_tx model control (written only by the main process).
    bit tx_hold = 1'b0;

    always @(negedge clk) begin
        if (bus.tx_send)     got.push_back(bus.tx_data);
        if (bus.frame_done)  n_done++;
        if (bus.err_cmd)     n_errcmd++;
        if (bus.err_timeout) n_errto++;
        if (bus.busy)        n_busy++;
    end

    // uart_tx model: busy for 10 cycles after each load; tx_hold keeps it busy.
    initial begin
        int cnt;
        cnt = 0;
        bus.tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.tx_send) begin
                cnt = 10;
                bus.tx_ready = 1'b0;
            end else begin
                if (cnt > 0) cnt--;
                if (cnt == 0 && !tx_hold) bus.tx_ready = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        step();
        bus.rx_data  = b;
        bus.rx_ready = 1'b1;
        step();
        bus.rx_ready = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n;
        n = 0;
        while (bus.busy && n < limit) begin
            step();
            n++;
        end
        check({tag, "_idle_in_time"}, 32'(n < limit), 32'd1);
    endtask

    task automatic wait_sends(input string tag, input int count, input int limit);
        int n;
        n = 0;
        while (got.size() < count && n < limit) begin
            step();
            n++;
        end
        check({tag, "_sends_in_time"}, 32'(n < limit), 32'd1);
    endtask

    // Reference frame: label/LSB/MSB for channels first..last, then XOR of all.
    function automatic byte_q_t model_frame(input logic [63:0] data,
                                            input int first, input int last);
        byte_q_t q;
        logic [7:0]  cks;
        logic [15:0] s;
        cks = 8'h00;
        for (int c = first; c <= last; c++) begin
            s = data[c*16 +: 16];
            q.push_back(8'h30 + 8'(c));
            q.push_back(s[7:0]);
            q.push_back(s[15:8]);
        end
        foreach (q[i]) cks ^= q[i];
        q.push_back(cks);
        return q;
    endfunction

    task automatic check_frame(input string tag, input int base, input byte_q_t exp_q);
        logic [31:0] obs;
        check({tag, "_len"}, 32'(got.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = (base + i < got.size()) ? 32'(got[base + i]) : 32'hFFFF_FFFF;
            check($sformatf("%s_byte%0d", tag, i), obs, 32'(exp_q[i]));
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {20'd0, bus.busy, bus.tx_send, bus.tx_data,
                bus.frame_done, bus.err_cmd};
    endfunction

    initial begin
        int b0, d0, e0, t0, k0, n;
        byte_q_t exp_q;
        logic [63:0] p1;

        p1 = 64'h4444_3333_2222_1111;
        bus.rx_ready = 1'b0;
        bus.rx_data  = 8'h00;
        bus.ch_data  = p1;
        reset_b      = 1'b0;
        repeat (3) step();

        // ---- Reset state ----
        check("reset_outputs", out_vec(), 32'd0);
        check("reset_err_timeout", 32'(bus.err_timeout), 32'd0);
        reset_b = 1'b1;
        repeat (2) step();

        // ---- 1: all channels, checksum of this pattern is 0x00 ----
        b0 = got.size(); d0 = n_done;
        send_cmd(8'h41);
        check("t1_busy_after_cmd", 32'(bus.busy), 32'd1);
        check("t1_no_send_yet", 32'(bus.tx_send), 32'd0);
        step();
        check("t1_first_send_latency", 32'(bus.tx_send), 32'd1);
        check("t1_first_byte", 32'(bus.tx_data), 32'h30);
        wait_idle("t1", 1000);
        exp_q = model_frame(p1, 0, 3);
        check_frame("t1", b0, exp_q);
        check("t1_frame_done_once", 32'(n_done - d0), 32'd1);
        check("t1_busy_low", 32'(bus.busy), 32'd0);

        // ---- 2: single channel 2 ----
        bus.ch_data = 64'h0000_BEEF_0000_0000;
        b0 = got.size(); d0 = n_done;
        send_cmd(8'h32);
        wait_idle("t2", 1000);
        exp_q = '{8'h32, 8'hEF, 8'hBE, 8'h63};
        check_frame("t2", b0, exp_q);
        check("t2_frame_done_once", 32'(n_done - d0), 32'd1);

        // ---- 3: unknown command and out-of-range channel ----
        b0 = got.size(); e0 = n_errcmd; k0 = n_busy;
        send_cmd(8'h5A);
        repeat (3) step();
        check("t3_errcmd_5a", 32'(n_errcmd - e0), 32'd1);
        send_cmd(8'h34);
        repeat (3) step();
        check("t3_errcmd_34", 32'(n_errcmd - e0), 32'd2);
        check("t3_no_send", 32'(got.size() - b0), 32'd0);
        check("t3_busy_never", 32'(n_busy - k0), 32'd0);

        // ---- 4: snapshot isolation and command while busy ----
        bus.ch_data = 64'hA1B2_C3D4_E5F6_0718;
        b0 = got.size(); d0 = n_done; e0 = n_errcmd;
        send_cmd(8'h41);
        wait_sends("t4", b0 + 3, 200);
        bus.ch_data = 64'hFFFF_FFFF_FFFF_FFFF;
        send_cmd(8'h41);
        wait_idle("t4", 1000);
        exp_q = model_frame(64'hA1B2_C3D4_E5F6_0718, 0, 3);
        check_frame("t4", b0, exp_q);
        check("t4_errcmd_busy", 32'(n_errcmd - e0), 32'd1);
        check("t4_frame_done_once", 32'(n_done - d0), 32'd1);

        // ---- 5: tx_ready stuck low after the 3rd byte -> timeout ----
        bus.ch_data = p1;
        b0 = got.size(); d0 = n_done; t0 = n_errto;
        send_cmd(8'h41);
        wait_sends("t5", b0 + 3, 200);
        tx_hold = 1'b1;
        n = 0;
        while (n_errto == t0 && n < 200) begin
            step();
            n++;
        end
        check("t5_timeout_not_early", 32'(n >= 50), 32'd1);
        check("t5_timeout_not_late", 32'(n < 60), 32'd1);
        check("t5_busy_low", 32'(bus.busy), 32'd0);
        repeat (20) step();
        check("t5_errto_once", 32'(n_errto - t0), 32'd1);
        check("t5_no_frame_done", 32'(n_done - d0), 32'd0);
        check("t5_no_more_sends", 32'(got.size() - b0), 32'd3);
        tx_hold = 1'b0;
        repeat (15) step();
        b0 = got.size(); d0 = n_done;
        send_cmd(8'h41);
        wait_idle("t5b", 1000);
        exp_q = model_frame(p1, 0, 3);
        check_frame("t5b", b0, exp_q);
        check("t5b_frame_done_once", 32'(n_done - d0), 32'd1);

        // ---- 6: asynchronous reset while waiting for byte 5 to finish ----
        bus.ch_data = 64'h1234_5678_9ABC_DEF0;
        b0 = got.size();
        send_cmd(8'h41);
        wait_sends("t6", b0 + 5, 200);
        repeat (4) step();
        check("t6_busy_before_reset", 32'(bus.busy), 32'd1);
        #1 reset_b = 1'b0;
        #1;
        check("t6_async_reset_outputs", out_vec(), 32'd0);
        check("t6_async_reset_err_timeout", 32'(bus.err_timeout), 32'd0);
        step();
        reset_b = 1'b1;
        repeat (15) step();
        b0 = got.size(); d0 = n_done;
        send_cmd(8'h30);
        wait_idle("t6b", 1000);
        exp_q = model_frame(64'h1234_5678_9ABC_DEF0, 0, 0);
        check_frame("t6b", b0, exp_q);
        check("t6b_frame_done_once", 32'(n_done - d0), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
